// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and config record for the clk_div_gen channels
package clk_div_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int P_MIN     = 2;

    localparam int RST_P = 2;
    localparam int RST_H = 1;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] period;
        logic [CNT_W_DEF-1:0] high;
    } cfg_t;

endpackage

// File: rtl/clk_div_gen_if.sv
// rtl/clk_div_gen_if.sv - config write port (valid/ready) of clk_div_gen
interface clk_div_gen_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_high;

    modport master (
        output cfg_valid, cfg_ch, cfg_period, cfg_high,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_period, cfg_high,
        output cfg_ready
    );
endinterface

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, shadow/active period and high time, pending flag
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_period,
    input  logic [CNT_W-1:0] wr_high,
    output logic             pending,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] P_LO = CNT_W'(P_MIN);

    logic [CNT_W-1:0] cnt, act_p, act_h, sh_p, sh_h;
    logic [CNT_W-1:0] cnt_n, nxt_p, nxt_h;
    logic             wrap, apply;

    assign wrap = (cnt == act_p - ONE);

    // A disabled channel takes its pending config immediately; a running one only at a period boundary.
    always_comb begin
        apply = 1'b0;
        cnt_n = cnt + ONE;
        nxt_p = act_p;
        nxt_h = act_h;
        if (!en) begin
            apply = pending;
        end else if (sync || wrap) begin
            apply = pending;
            cnt_n = '0;
        end
        if (apply) begin
            nxt_p = sh_p;
            nxt_h = sh_h;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= CNT_W'(RST_P - 1);
            act_p   <= CNT_W'(RST_P);
            act_h   <= CNT_W'(RST_H);
            sh_p    <= CNT_W'(RST_P);
            sh_h    <= CNT_W'(RST_H);
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            if (wr) begin
                sh_p    <= (wr_period < P_LO) ? P_LO : wr_period;
                sh_h    <= wr_high;
                pending <= 1'b1;
            end else if (apply) begin
                pending <= 1'b0;
            end
            act_p <= nxt_p;
            act_h <= nxt_h;
            if (en) begin
                cnt     <= cnt_n;
                clk_out <= (cnt_n < nxt_h);
                tick    <= (cnt_n == '0);
            end else begin
                cnt     <= nxt_p - ONE;
                clk_out <= 1'b0;
                tick    <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_gen.sv
// rtl/clk_div_gen.sv - NUM_CH programmable clock dividers with period ticks; CLK_DIV_SYNC_EN adds sync_in
module clk_div_gen
    import clk_div_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CLK_DIV_SYNC_EN
    input  logic              sync_in,
`endif
    clk_div_gen_if.slave      cfg,
    input  logic [NUM_CH-1:0] en,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0]    pending;
    logic [2**CH_W-1:0]   pend_ext;
    logic                 sync;

`ifdef CLK_DIV_SYNC_EN
    assign sync = sync_in;
`else
    assign sync = 1'b0;
`endif

    // Unimplemented channel numbers read as never-pending so their writes complete and vanish.
    always_comb begin
        pend_ext = '0;
        pend_ext[NUM_CH-1:0] = pending;
    end

    assign cfg.cfg_ready = !pend_ext[cfg.cfg_ch];

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic wr;
        assign wr = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_ch == CH_W'(gi));

        clk_div_chan #(.CNT_W(CNT_W)) u_chan (
            .clk       (clk),
            .rst       (rst),
            .en        (en[gi]),
            .sync      (sync),
            .wr        (wr),
            .wr_period (cfg.cfg_period),
            .wr_high   (cfg.cfg_high),
            .pending   (pending[gi]),
            .clk_out   (clk_out[gi]),
            .tick      (tick[gi])
        );
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb/tb_clk_div_gen.sv - directed self-checking bench for clk_div_gen
module tb_clk_div_gen;
    import clk_div_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] en;
    logic [1:0] clk_out;
    logic [1:0] tick;
`ifdef CLK_DIV_SYNC_EN
    logic       sync_in;
`endif

    int n_checks = 0;
    int n_errors = 0;

    clk_div_gen_if #(.NUM_CH(2), .CNT_W(8)) bus ();

    clk_div_gen #(.NUM_CH(2), .CNT_W(8)) dut (
        .clk     (clk),
        .rst     (rst),
`ifdef CLK_DIV_SYNC_EN
        .sync_in (sync_in),
`endif
        .cfg     (bus.slave),
        .en      (en),
        .clk_out (clk_out),
        .tick    (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_pat(input string tag, input int n,
                           input logic [31:0] exp_clk, input logic [31:0] exp_tick);
        for (int i = 0; i < n; i++) begin
            step();
            check({tag, "_clk0"}, 32'(clk_out[0]), 32'(exp_clk[i]));
            check({tag, "_tick0"}, 32'(tick[0]), 32'(exp_tick[i]));
            check({tag, "_ch1"}, 32'({clk_out[1], tick[1]}), 32'd0);
        end
    endtask

    task automatic drive_cfg(input logic ch, input cfg_t c);
        bus.cfg_valid  = 1'b1;
        bus.cfg_ch     = ch;
        bus.cfg_period = c.period;
        bus.cfg_high   = c.high;
    endtask

    task automatic cfg_write(input logic ch, input cfg_t c);
        int waited = 0;
        logic done = 1'b0;
        drive_cfg(ch, c);
        while (!done && waited < 64) begin
            if (bus.cfg_ready) done = 1'b1;
            step();
            waited++;
        end
        bus.cfg_valid = 1'b0;
        check("cfg_write_accept", 32'(done), 32'd1);
    endtask

    initial begin
        rst            = 1'b1;
        en             = 2'b00;
        bus.cfg_valid  = 1'b0;
        bus.cfg_ch     = 1'b0;
        bus.cfg_period = '0;
        bus.cfg_high   = '0;
`ifdef CLK_DIV_SYNC_EN
        sync_in        = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_ready", 32'(bus.cfg_ready), 32'd1);
        rst = 1'b0;

        // defaults P=2 H=1 on ch0
        en = 2'b01;
        run_pat("dflt", 4, 32'h5, 32'h5);

        // ch0 -> P=5 H=2 written mid-period
        step();
        drive_cfg(1'b0, '{period: 8'd5, high: 8'd2});
        check("p5_ready_before", 32'(bus.cfg_ready), 32'd1);
        step();
        bus.cfg_valid = 1'b0;
        check("p5_ready_pending", 32'(bus.cfg_ready), 32'd0);
        check("p5_old_period", 32'(clk_out[0]), 32'd0);
        step();
        check("p5_ready_applied", 32'(bus.cfg_ready), 32'd1);
        check("p5_first_clk", 32'(clk_out[0]), 32'd1);
        check("p5_first_tick", 32'(tick[0]), 32'd1);
        run_pat("p5", 9, 32'h031, 32'h010);

        // P=0 H=0 clamps to period 2, constant low
        drive_cfg(1'b0, '{period: 8'd0, high: 8'd0});
        check("p0_ready", 32'(bus.cfg_ready), 32'd1);
        step();
        bus.cfg_valid = 1'b0;
        run_pat("p0", 8, 32'h01, 32'h50);

        // P=4 H=9 gives constant high
        drive_cfg(1'b0, '{period: 8'd4, high: 8'd9});
        check("h9_ready", 32'(bus.cfg_ready), 32'd1);
        step();
        bus.cfg_valid = 1'b0;
        run_pat("h9", 9, 32'h1FE, 32'h022);

        // back-to-back writes: second stalls until the first applies
        drive_cfg(1'b0, '{period: 8'd3, high: 8'd1});
        check("b2b_ready_first", 32'(bus.cfg_ready), 32'd1);
        step();
        drive_cfg(1'b0, '{period: 8'd6, high: 8'd3});
        check("b2b_stall0", 32'(bus.cfg_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("b2b_stall", 32'(bus.cfg_ready), 32'd0);
        end
        step();
        check("b2b_apply_ready", 32'(bus.cfg_ready), 32'd1);
        check("b2b_apply_clk", 32'(clk_out[0]), 32'd1);
        check("b2b_apply_tick", 32'(tick[0]), 32'd1);
        step();
        bus.cfg_valid = 1'b0;
        check("b2b_second_pending", 32'(bus.cfg_ready), 32'd0);
        step();
        check("b2b_p3_ready", 32'(bus.cfg_ready), 32'd0);
        check("b2b_p3_clk", 32'(clk_out[0]), 32'd0);
        step();
        check("b2b_p6_ready", 32'(bus.cfg_ready), 32'd1);
        check("b2b_p6_tick", 32'(tick[0]), 32'd1);
        check("b2b_p6_clk", 32'(clk_out[0]), 32'd1);
        run_pat("p6", 6, 32'h23, 32'h20);

        // enable dropped at cnt=1 of P=5
        drive_cfg(1'b0, '{period: 8'd5, high: 8'd2});
        step();
        bus.cfg_valid = 1'b0;
        repeat (4) step();
        step();
        check("en_wrap_tick", 32'(tick[0]), 32'd1);
        step();
        check("en_cnt1_clk", 32'(clk_out[0]), 32'd1);
        check("en_cnt1_tick", 32'(tick[0]), 32'd0);
        en = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("en_low_clk", 32'(clk_out[0]), 32'd0);
            check("en_low_tick", 32'(tick[0]), 32'd0);
        end
        en = 2'b01;
        step();
        check("en_rise_tick", 32'(tick[0]), 32'd1);
        check("en_rise_clk", 32'(clk_out[0]), 32'd1);
        step();
        check("en_rise2_tick", 32'(tick[0]), 32'd0);
        check("en_rise2_clk", 32'(clk_out[0]), 32'd1);
        step();
        check("en_rise3_clk", 32'(clk_out[0]), 32'd0);

        // disabled ch1 applies on the next edge, then runs P=3 H=1
        drive_cfg(1'b1, '{period: 8'd3, high: 8'd1});
        check("ch1_ready", 32'(bus.cfg_ready), 32'd1);
        step();
        bus.cfg_valid = 1'b0;
        check("ch1_pending", 32'(bus.cfg_ready), 32'd0);
        step();
        check("ch1_applied", 32'(bus.cfg_ready), 32'd1);
        en = 2'b11;
        for (int i = 0; i < 4; i++) begin
            step();
            check("ch1_clk", 32'(clk_out[1]), 32'((i % 3) == 0));
            check("ch1_tick", 32'(tick[1]), 32'((i % 3) == 0));
        end

`ifdef CLK_DIV_SYNC_EN
        cfg_write(1'b0, '{period: 8'd4, high: 8'd2});
        cfg_write(1'b1, '{period: 8'd6, high: 8'd3});
        repeat (14) step();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        check("sync_tick", 32'(tick), 32'd3);
        check("sync_clk", 32'(clk_out), 32'd3);
        for (int k = 1; k <= 12; k++) begin
            step();
            check("sync_run_tick", 32'(tick), 32'({(k % 6) == 0, (k % 4) == 0}));
        end
`else
        cfg_write(1'b0, '{period: 8'd4, high: 8'd2});
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Synthesizable, parametrised successor to the bench-only fixed-half-period clock toggler.
- NUM_CH independent channels, each producing a divided clock with programmable period and high time, plus a period-start tick.
- Configuration is written over a valid/ready port and applied glitch-free at the channel's next period boundary.
- Used as the shared clock/strobe source for assignment designs and their benches.

Parameters:
- NUM_CH, 2, number of output channels (1..16).
- CNT_W, 8, counter and config field width; period range 2..2^CNT_W-1.
- CH_W, $clog2(NUM_CH) (min 1), channel-select width; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write can be accepted.
- cfg_ch  in  CH_W  target channel.
- cfg_period  in  CNT_W  period P in clk cycles.
- cfg_high  in  CNT_W  high time H in clk cycles.
- en  in  NUM_CH  per-channel run enable.
- clk_out  out  NUM_CH  divided clocks, registered.
- tick  out  NUM_CH  1-cycle pulse on the first cycle of each period, registered.

Behaviour:
- Reset (async assert, sync release):
  - Every channel: P=2, H=1, cnt=P-1.
  - clk_out=0, tick=0, pending=0, cfg_ready=1.
- Per-channel state: cnt, active P/H, shadow P/H, pending flag.
- Enabled channel, each edge:
  - cnt_n = (cnt==P-1) ? 0 : cnt+1.
  - clk_out <= (cnt_n < H).
  - tick <= (cnt_n==0).
- Disabled channel: cnt held at P-1, clk_out=0, tick=0.
  - First edge with en sampled high wraps cnt to 0.
  - tick and clk_out (if H>0) assert one cycle after en is first sampled high.
- Clamping: P<2 is stored as 2. H=0 gives constant 0; H>=P gives constant 1; tick still pulses.
- Config handshake:
  - Transfer on cfg_valid && cfg_ready.
  - cfg_ready = !pending[cfg_ch], combinational from cfg_ch.
  - Accepted write loads shadow P/H and sets pending.
- Apply rule:
  - Enabled channel: shadow is copied to active P/H on the wrap edge (cnt==P-1). cnt_n, clk_out and tick on that edge use the new H. pending clears on the same edge.
  - Disabled channel: apply on the next edge; cnt is set to new P-1.
- Simultaneous accept and apply on the same channel cannot occur, because cfg_ready is low while pending.
- en dropping mid-period: next edge gives clk_out=0 and cnt=P-1; any pending config applies.
- Channels are fully independent; writes to channel A never disturb channel B.
- cfg_ch >= NUM_CH: write is accepted and discarded.

Optional Feature:
- Macro: CLK_DIV_SYNC_EN.
- Defined: adds input sync_in (1 bit).
  - Edge with sync_in high: every enabled channel applies any pending config, forces cnt_n=0, and sets tick=1 and clk_out=(H>0).
  - sync takes priority over normal wrap and over en rising.
  - Disabled channels ignore sync.
- Undefined: port absent; channels free-run from their own enable edges only.

Decomposition:
- Package clk_div_pkg:
  - CNT_W default and the P_MIN=2 constant.
  - typedef struct cfg_t {period, high}.
  - Reset constants RST_P and RST_H.
- Sub-module clk_div_chan: one channel (counter, shadow/active regs, pending, outputs).
  - Instantiated NUM_CH times by a generate loop in clk_div_gen.
  - Top level holds the cfg_ch decode and the cfg_ready mux.

Test Plan:
- Reset then en=2'b01, defaults → clk_out[0] toggles 0→1 one cycle after en, period 2, 50% duty; tick every 2 cycles; clk_out[1]=0.
- Write ch0 P=5 H=2 while running mid-period → old period completes; then repeating pattern 1,1,0,0,0 with tick on the first 1; cfg_ready low until the wrap edge.
- Write P=0 H=0, then P=4 H=9 → first gives period 2 with constant 0 and ticks; second gives period 4 with constant 1 and ticks every 4.
- Second write to same channel while pending → cfg_ready=0 and cfg_valid held; the write is accepted on the cycle after the apply edge.
- Drop en at cnt=1 of P=5, raise 3 cycles later → clk_out 0 while low; tick exactly one cycle after en is sampled high.
- CLK_DIV_SYNC_EN: ch0 P=4 and ch1 P=6 running; pulse sync_in → both tick on the same edge; rising edges coincide every 12 cycles.
